// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a 2-entry skid buffer.
// Define IMM_GEN_ZIMM_EN to decode imm_src 101 as the CSR zimm; otherwise it is reserved.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int SRC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [SRC_W-1:0] imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic             imm_err
);
    logic [XLEN-1:0] imm, skid_imm;
    logic            err, skid_err, skid_full, drain, acc;

    // instr[n] carries Instr[n+7]; signed casts provide the sign extension
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_src)
            SRC_W'(0): imm = XLEN'($signed(instr[24:13]));
            SRC_W'(1): imm = XLEN'($signed({instr[24:5], 12'b0}));
            SRC_W'(2): imm = XLEN'($signed({instr[24:18], instr[4:0]}));
            SRC_W'(3): imm = XLEN'($signed({instr[24], instr[0], instr[23:18], instr[4:1], 1'b0}));
            SRC_W'(4): imm = XLEN'($signed({instr[24], instr[12:5], instr[13], instr[23:14], 1'b0}));
`ifdef IMM_GEN_ZIMM_EN
            SRC_W'(5): imm = XLEN'(instr[12:8]);
`endif
            default:   err = 1'b1;
        endcase
    end

    assign in_ready = !skid_full;
    assign drain    = out_valid && out_ready;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            imm_ext   <= '0;
            imm_err   <= 1'b0;
            skid_full <= 1'b0;
            skid_imm  <= '0;
            skid_err  <= 1'b0;
        end else if (skid_full) begin
            if (drain) begin
                imm_ext   <= skid_imm;
                imm_err   <= skid_err;
                skid_full <= 1'b0;
            end
        end else if (acc && (!out_valid || drain)) begin
            out_valid <= 1'b1;
            imm_ext   <= imm;
            imm_err   <= err;
        end else if (acc) begin
            skid_full <= 1'b1;
            skid_imm  <= imm;
            skid_err  <= err;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized scoreboard bench for imm_gen_pipe at XLEN 32 and 64.
module tb_imm_gen_pipe;
    logic        clk, rst, in_valid, out_ready;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic        in_ready32, out_valid32, err32, in_ready64, out_valid64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [64:0] q[$];
    logic [63:0] outs[$];
    int          checks, failures;
    bit          accepted;
`ifdef IMM_GEN_ZIMM_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    imm_gen_pipe #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_ext(imm32), .imm_err(err32));
    imm_gen_pipe #(.XLEN(64)) u64 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
        .imm_ext(imm64), .imm_err(err64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {err, imm64} assembled from the instruction word field by field
    function automatic logic [64:0] model(input logic [31:0] w, input logic [2:0] s);
        logic [63:0] sg = {64{w[31]}};
        case (s)
            3'd0: return {1'b0, (sg << 12) | 64'(w >> 20)};
            3'd1: return {1'b0, (sg << 32) | 64'(w & 32'hFFFFF000)};
            3'd2: return {1'b0, (sg << 12) | 64'((w >> 25) << 5) | 64'((w >> 7) & 32'h1f)};
            3'd3: return {1'b0, (sg << 12) | 64'(((w >> 7) & 32'h1) << 11)
                          | 64'(((w >> 25) & 32'h3f) << 5) | 64'(((w >> 8) & 32'hf) << 1)};
            3'd4: return {1'b0, (sg << 20) | 64'(((w >> 12) & 32'hff) << 12)
                          | 64'(((w >> 20) & 32'h1) << 11) | 64'(((w >> 21) & 32'h3ff) << 1)};
            3'd5: return ZEN ? {1'b0, 64'((w >> 15) & 32'h1f)} : {1'b1, 64'd0};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    task automatic step(input logic v, input logic [31:0] w, input logic [2:0] s, input logic r);
        logic [64:0] e;
        @(negedge clk);
        in_valid = v; instr = w[31:7]; imm_src = s; out_ready = r;
        #1;
        chk("out_valid32", out_valid32, q.size() > 0);
        chk("out_valid64", out_valid64, q.size() > 0);
        chk("in_ready32", in_ready32, q.size() < 2);
        chk("in_ready64", in_ready64, q.size() < 2);
        if (q.size() > 0) begin
            e = q[0];
            chk("imm32", imm32, e[31:0]);
            chk("imm64", imm64, e[63:0]);
            chk("err32", err32, e[64]);
            chk("err64", err64, e[64]);
        end
        accepted = v && q.size() < 2;
        if (q.size() > 0 && r) begin
            e = q.pop_front();
            outs.push_back(e[63:0]);
        end
        if (accepted) q.push_back(model(w, s));
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 3'd0, 1'b1);
    endtask

    task automatic single(input string tag, input logic [31:0] w, input logic [2:0] s,
                          input logic [63:0] e, input logic ee);
        step(1'b1, w, s, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        chk({tag, "_v"}, out_valid32, 1'b1);
        chk({tag, "_32"}, imm32, e[31:0]);
        chk({tag, "_64"}, imm64, e);
        chk({tag, "_err"}, err32, ee);
        flush();
    endtask

    initial begin
        int k, n;
        logic [31:0] w;
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; imm_src = '0;
        #1;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_err", err32, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush();

        single("I",  32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        single("B",  32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        single("J",  32'h0080006F, 3'd4, 64'h0000000000000008, 1'b0);
        single("S",  32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        single("U1", 32'h123450B7, 3'd1, 64'h0000000012345000, 1'b0);
        single("U2", 32'h800000B7, 3'd1, 64'hFFFFFFFF80000000, 1'b0);
        single("R7", 32'hFFFFFFFF, 3'd7, 64'd0, 1'b1);
        single("Z",  32'h000F8073, 3'd5, ZEN ? 64'h1F : 64'd0, !ZEN);

        // backpressure: offer 1..4 in order, each held until accepted
        outs.delete();
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ((k + 1) << 20) | 32'h93, 3'd0, 1'b0);
            k += int'(accepted);
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready32, 1'b0);
        n = 0;
        while ((k < 4 || q.size() > 0) && n < 30) begin
            step(k < 4, ((k + 1) << 20) | 32'h93, 3'd0, 1'b1);
            k += int'(accepted);
            n++;
        end
        chk("bp_timeout", n < 30, 1'b1);
        chk("bp_count", outs.size(), 4);
        for (int i = 0; i < 4 && i < outs.size(); i++) chk("bp_order", outs[i], 64'(i + 1));

        // reset with both entries occupied
        step(1'b1, 32'h00500093, 3'd0, 1'b0);
        step(1'b1, 32'h00600093, 3'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", in_ready32, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_v32", out_valid32, 1'b0);
        chk("mid_rst_v64", out_valid64, 1'b0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 3'd0, 1'b1);
        chk("post_rst_ready", in_ready32, 1'b1);

        for (int i = 0; i < 500; i++) begin
            w = $urandom;
            step($urandom_range(0, 3) != 0, w, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
        end
        flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
